fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID register consumer (decode).
- Owns the PC register and the instruction-memory request/ihit handshake.
- Applies EX/MEM branch/jump redirects and downstream stalls, then produces the registered IF/ID fields consumed by decode: imemload, pc, pc4, npc, plus a valid bit.
- Predicts not-taken: npc = pc + 4.

Parameters:
PC_INIT, 32'h00000000, PC value loaded on reset.

Ports:
CLK  input  1  rising-edge clock.
nRST  input  1  asynchronous active-low reset.
ihit  input  1  instruction memory returned data for imemaddr this cycle.
imemload_in  input  32  instruction word from instruction memory, valid when ihit=1.
imemREN  output  1  instruction read request.
imemaddr  output  32  fetch address; always equals pc.
stall  input  1  decode cannot accept a new IF/ID entry this cycle.
redirect  input  1  resolved taken branch/jump/jr from EX/MEM; flush and retarget.
redirect_pc  input  32  target address for redirect.
halt_in  input  1  halt retired; freeze fetch permanently.
ifid_imemload  output  32  registered instruction.
ifid_pc  output  32  registered PC of that instruction.
ifid_pc4  output  32  registered PC+4.
ifid_npc  output  32  registered predicted next PC (= pc4).
ifid_valid  output  1  1 = real instruction, 0 = bubble.
fetch_cnt  output  32  count of instructions delivered to IF/ID; used by the cpu tracker.

Behaviour:
- Reset (async, nRST=0): pc=PC_INIT, state=RUN, all ifid_* outputs = 0, ifid_valid=0, fetch_cnt=0. Reset mid-fetch abandons the request with no side effects.
- States: RUN, HALTED.
  - RUN: imemREN=1.
  - HALTED: imemREN=0. Every register holds; redirect, stall and ihit are ignored. Only reset exits HALTED.
- imemaddr = pc, combinationally, in both states.
- pc4 = pc + 32'd4, modulo 2^32: 32'hFFFFFFFC wraps to 0.
- Per-cycle priority in RUN, highest first:
  1. halt_in=1: next state HALTED; pc holds; IF/ID loads a bubble (all fields 0, valid 0); fetch_cnt holds.
  2. redirect=1: pc <= {redirect_pc[31:2], 2'b00}. Low bits are forced zero. IF/ID loads a bubble regardless of stall and ihit; the in-flight fetch is discarded and fetch_cnt holds. Flush dominates stall.
  3. stall=1: pc and all IF/ID registers hold. An ihit arriving in this cycle is discarded and the same pc is refetched later; fetch_cnt holds.
  4. ihit=1: pc <= pc4. IF/ID loads imemload=imemload_in, pc=pc, pc4=pc4, npc=pc4, valid=1. fetch_cnt <= fetch_cnt + 1, wrapping.
  5. Otherwise (no ihit, no stall): pc holds; IF/ID loads a bubble so decode advances a nop.
- Latency: instruction visible on ifid_* on the clock edge after the cycle in which ihit=1. With ihit tied high, throughput is 1 instruction/cycle.
- Bubble encoding: imemload=32'h0 (sll $0 nop), pc/pc4/npc=0, valid=0.
- imemload_in is sampled only when ihit=1. It is don't-care otherwise.
- redirect_pc is sampled only when redirect=1.

Test Plan:
- Reset, PC_INIT=0, ihit tied 1, stall=0, memory returns word = address+0x100 -> ifid_pc=0,4,8 on consecutive cycles; ifid_imemload=0x100,0x104,0x108; ifid_npc=ifid_pc4; fetch_cnt=3 after 3 edges.
- ihit pattern 1,0,0,1 from pc=0x10 -> IF/ID shows pc 0x10 valid, two bubbles (valid=0, imemload=0), then pc 0x14; fetch_cnt +2.
- stall=1 for 2 cycles with ihit=1 at pc=0x20 -> ifid_* and pc hold; imemaddr stays 0x20; after stall drops, ifid_pc=0x20 delivered once, fetch_cnt +1.
- redirect=1, redirect_pc=0x403, together with stall=1 and ihit=1 at pc=0x30 -> next cycle imemaddr=0x400, ifid_valid=0, fetch_cnt unchanged.
- halt_in=1 at pc=0x50, then redirect=1 and ihit=1 -> imemREN=0, pc stays 0x50, IF/ID bubble; assert nRST=0 -> pc=PC_INIT, state RUN, imemREN=1.
- pc=0xFFFFFFFC, ihit=1 -> ifid_pc4=0x00000000, next imemaddr=0x00000000.

Source files
------------

// File: rtl/fetch_if.sv
// Instruction-memory handshake between the fetch stage and instruction memory.
interface fetch_if;
  logic        ihit;
  logic [31:0] imemload_in;
  logic        imemREN;
  logic [31:0] imemaddr;

  // fetch stage issues the request, memory answers
  modport master (input ihit, imemload_in, output imemREN, imemaddr);
  modport slave  (output ihit, imemload_in, input imemREN, imemaddr);
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, imem request, redirect/stall/halt
// handling and the registered IF/ID fields handed to decode.
// Prediction is always not-taken (npc = pc + 4).
module fetch_stage #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  fetch_if.master     imem,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt_in,
  output logic [31:0] ifid_imemload,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_npc,
  output logic        ifid_valid,
  output logic [31:0] fetch_cnt
);

  typedef enum logic {RUN, HALTED} state_t;

  typedef struct packed {
    logic [31:0] imemload;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] npc;
    logic        valid;
  } ifid_t;

  // all-zero entry: imemload 0 is sll $0,$0,0, i.e. a nop
  localparam ifid_t BUBBLE = '0;

  state_t      state, state_n;
  logic [31:0] pc, pc_n, pc4;
  logic [31:0] cnt, cnt_n;
  ifid_t       ifid, ifid_n;

  assign pc4           = pc + 32'd4;  // wraps naturally at 2^32
  assign imem.imemaddr = pc;
  assign imem.imemREN  = (state == RUN);

  assign ifid_imemload = ifid.imemload;
  assign ifid_pc       = ifid.pc;
  assign ifid_pc4      = ifid.pc4;
  assign ifid_npc      = ifid.npc;
  assign ifid_valid    = ifid.valid;
  assign fetch_cnt     = cnt;

  // State, PC, IF/ID and delivery counter registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= RUN;
      pc    <= PC_INIT;
      ifid  <= BUBBLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ifid  <= ifid_n;
      cnt   <= cnt_n;
    end
  end

  // Next-state: halt > redirect > stall > ihit > bubble; HALTED freezes everything
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ifid_n  = ifid;
    cnt_n   = cnt;
    case (state)
      RUN: begin
        if (halt_in) begin
          state_n = HALTED;
          ifid_n  = BUBBLE;
        end else if (redirect) begin
          // flush wins over stall; the in-flight fetch is dropped
          pc_n   = {redirect_pc[31:2], 2'b00};
          ifid_n = BUBBLE;
        end else if (stall) begin
          // hold everything; an ihit now is dropped and this pc is refetched
          pc_n   = pc;
        end else if (imem.ihit) begin
          pc_n   = pc4;
          ifid_n = '{imemload: imem.imemload_in, pc: pc, pc4: pc4, npc: pc4, valid: 1'b1};
          cnt_n  = cnt + 32'd1;
        end else begin
          ifid_n = BUBBLE;
        end
      end
      HALTED: begin
        state_n = HALTED;
      end
      default: state_n = RUN;
    endcase
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: memory returns address+0x100; vector table with
// hand-computed expected IF/ID contents, checked through a scoreboard queue.
module tb_fetch_stage;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        stall = 1'b0, redirect = 1'b0, halt_in = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] ifid_imemload, ifid_pc, ifid_pc4, ifid_npc, fetch_cnt;
  logic        ifid_valid;

  int checks = 0;
  int errors = 0;

  fetch_if bus ();

  assign bus.imemload_in = bus.imemaddr + 32'h100;

  fetch_stage #(.PC_INIT(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .imem(bus.master),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc), .halt_in(halt_in),
    .ifid_imemload(ifid_imemload), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
    .ifid_npc(ifid_npc), .ifid_valid(ifid_valid), .fetch_cnt(fetch_cnt)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        halt, redir;
    logic [31:0] rpc;
    logic        stl, ihit;
    logic [31:0] addr;   // expected imemaddr before the edge
    logic        ren;    // expected imemREN before the edge
    logic        valid;
    logic [31:0] pc, load, pc4, cnt;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] pc, load, pc4, cnt;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(logic h, logic r, logic [31:0] rp, logic s, logic i,
                              logic [31:0] a, logic rn, logic v, logic [31:0] p,
                              logic [31:0] l, logic [31:0] p4, logic [31:0] c);
    vec_t t;
    t = '{halt:h, redir:r, rpc:rp, stl:s, ihit:i, addr:a, ren:rn, valid:v,
          pc:p, load:l, pc4:p4, cnt:c};
    return t;
  endfunction

  task automatic check_ifid(input string tag, input exp_t e);
    chk({tag, ".valid"}, {31'b0, ifid_valid}, {31'b0, e.valid});
    chk({tag, ".pc"},    ifid_pc,       e.pc);
    chk({tag, ".load"},  ifid_imemload, e.load);
    chk({tag, ".pc4"},   ifid_pc4,      e.pc4);
    chk({tag, ".npc"},   ifid_npc,      e.pc4);
    chk({tag, ".cnt"},   fetch_cnt,     e.cnt);
  endtask

  // drive one cycle at negedge, check request side, score IF/ID after the edge
  task automatic apply(input vec_t v, input string tag);
    exp_t e;
    @(negedge CLK);
    halt_in = v.halt; redirect = v.redir; redirect_pc = v.rpc;
    stall = v.stl; bus.ihit = v.ihit;
    #1;
    chk({tag, ".imemaddr"}, bus.imemaddr, v.addr);
    chk({tag, ".imemREN"}, {31'b0, bus.imemREN}, {31'b0, v.ren});
    sb.push_back('{valid:v.valid, pc:v.pc, load:v.load, pc4:v.pc4, cnt:v.cnt});
    @(posedge CLK);
    #1;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      check_ifid(tag, e);
    end
  endtask

  initial begin
    bus.ihit = 1'b0;
    //            halt red rpc           stl ihit addr          ren v  pc            load          pc4           cnt
    tbl[0]  = mk(0, 0, 0,            0, 1, 32'h0,        1, 1, 32'h0,        32'h100,      32'h4,        1);
    tbl[1]  = mk(0, 0, 0,            0, 1, 32'h4,        1, 1, 32'h4,        32'h104,      32'h8,        2);
    tbl[2]  = mk(0, 0, 0,            0, 1, 32'h8,        1, 1, 32'h8,        32'h108,      32'hC,        3);
    tbl[3]  = mk(0, 1, 32'h10,       0, 0, 32'hC,        1, 0, 0,            0,            0,            3);
    tbl[4]  = mk(0, 0, 0,            0, 1, 32'h10,       1, 1, 32'h10,       32'h110,      32'h14,       4);
    tbl[5]  = mk(0, 0, 0,            0, 0, 32'h14,       1, 0, 0,            0,            0,            4);
    tbl[6]  = mk(0, 0, 0,            0, 0, 32'h14,       1, 0, 0,            0,            0,            4);
    tbl[7]  = mk(0, 0, 0,            0, 1, 32'h14,       1, 1, 32'h14,       32'h114,      32'h18,       5);
    tbl[8]  = mk(0, 1, 32'h1C,       0, 0, 32'h18,       1, 0, 0,            0,            0,            5);
    tbl[9]  = mk(0, 0, 0,            0, 1, 32'h1C,       1, 1, 32'h1C,       32'h11C,      32'h20,       6);
    tbl[10] = mk(0, 0, 0,            1, 1, 32'h20,       1, 1, 32'h1C,       32'h11C,      32'h20,       6);
    tbl[11] = mk(0, 0, 0,            1, 1, 32'h20,       1, 1, 32'h1C,       32'h11C,      32'h20,       6);
    tbl[12] = mk(0, 0, 0,            0, 1, 32'h20,       1, 1, 32'h20,       32'h120,      32'h24,       7);
    tbl[13] = mk(0, 1, 32'h30,       0, 0, 32'h24,       1, 0, 0,            0,            0,            7);
    tbl[14] = mk(0, 1, 32'h403,      1, 1, 32'h30,       1, 0, 0,            0,            0,            7);
    tbl[15] = mk(0, 0, 0,            0, 1, 32'h400,      1, 1, 32'h400,      32'h500,      32'h404,      8);
    tbl[16] = mk(0, 1, 32'h50,       0, 0, 32'h404,      1, 0, 0,            0,            0,            8);
    tbl[17] = mk(1, 0, 0,            0, 1, 32'h50,       1, 0, 0,            0,            0,            8);
    tbl[18] = mk(0, 1, 32'h100,      0, 1, 32'h50,       0, 0, 0,            0,            0,            8);
    tbl[19] = mk(0, 0, 0,            1, 1, 32'h50,       0, 0, 0,            0,            0,            8);

    // reset state
    #12;
    chk("rst.imemaddr", bus.imemaddr, 32'h0);
    chk("rst.imemREN", {31'b0, bus.imemREN}, 32'h1);
    check_ifid("rst", '{valid:1'b0, pc:32'h0, load:32'h0, pc4:32'h0, cnt:32'h0});
    @(negedge CLK);
    nRST = 1'b1;

    for (int i = 0; i < 20; i++) apply(tbl[i], $sformatf("v%0d", i));

    // still frozen after extra halted cycle: pc stays, no request
    @(negedge CLK);
    chk("halt.imemaddr", bus.imemaddr, 32'h50);
    chk("halt.imemREN", {31'b0, bus.imemREN}, 32'h0);

    // async reset out of HALTED, asserted mid-cycle
    #2 nRST = 1'b0;
    #1;
    chk("rst2.imemaddr", bus.imemaddr, 32'h0);
    chk("rst2.imemREN", {31'b0, bus.imemREN}, 32'h1);
    check_ifid("rst2", '{valid:1'b0, pc:32'h0, load:32'h0, pc4:32'h0, cnt:32'h0});
    @(negedge CLK);
    nRST = 1'b1;

    // PC wrap at the top of the address space; low redirect bits dropped
    apply(mk(0, 1, 32'hFFFF_FFFE, 0, 0, 32'h0, 1, 0, 0, 0, 0, 0), "wrap.redir");
    apply(mk(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 32'h0000_00FC, 32'h0, 1), "wrap.fetch");
    @(negedge CLK);
    bus.ihit = 1'b0;
    #1;
    chk("wrap.imemaddr", bus.imemaddr, 32'h0);

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover=%0d", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
